p_liu_mem_sequencer: RTL
========================

Name: p_liu_mem_sequencer

Overview:
- Parametrised single-clock memory sequencer for the 16-bit core family.
- Replaces the dual-clock arrangement (instruction port on the slow clock, data port on the fast clock) with one shared single-port synchronous RAM.
- Accesses are time-multiplexed by an FSM. A one-cycle commit strobe gates all architectural register writes in the core.
- Sits between the core's logic sector (pc_next, data request) and the RAM. Adds configurable read latency, hold/stall, misalignment flag and retired-instruction counter.

Parameters:
- DATA_W, 16, instruction/data word width.
- ADDR_W, 16, core byte-address width.
- ADDR_SHIFT, 1, byte-to-word shift; MEM_AW = ADDR_W-ADDR_SHIFT (localparam).
- READ_LAT, 1, RAM read latency in cycles (1..4).
- RESET_PC, 0, byte address of the first fetch.
- CNT_W, 32, width of the retired counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- hold  in  1  stall core in EXEC while high.
- pc_next  in  ADDR_W  next-instruction byte address from the logic sector.
- data_req  in  1  current instruction needs a data access.
- data_we  in  1  1 = store, 0 = load (valid with data_req).
- data_addr  in  ADDR_W  data byte address.
- data_wdata  in  DATA_W  store data.
- instr  out  DATA_W  registered current instruction.
- instr_valid  out  1  high in EXEC, WAIT_D, COMMIT.
- data_rdata  out  DATA_W  registered load result.
- commit  out  1  one-cycle architectural write enable.
- retired  out  CNT_W  committed-instruction count.
- misalign  out  1  data access with nonzero low ADDR_SHIFT bits.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  MEM_AW  RAM word address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid READ_LAT cycles after the issue cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - state=BOOT; instr, data_rdata, retired, latency counter = 0.
  - All outputs 0: commit, mem_en, mem_we, misalign; mem_addr=0, mem_wdata=0.
- States:
  - BOOT: no access; always goes to FETCH next cycle.
  - FETCH: mem_en=1, mem_we=0, mem_addr=RESET_PC>>ADDR_SHIFT. Goes to WAIT_I.
  - WAIT_I: lasts READ_LAT cycles. On the last cycle, mem_rdata is captured into instr. Goes to EXEC.
  - EXEC: evaluated in priority order:
    - hold=1: stay in EXEC, no access issued.
    - data_req=0: go to COMMIT.
    - data_req=1, data_we=1: in this cycle drive mem_en=1, mem_we=1, mem_addr=data_addr>>ADDR_SHIFT, mem_wdata=data_wdata; then go to COMMIT.
    - data_req=1, data_we=0: issue the read (mem_en=1, mem_we=0, same address); go to WAIT_D.
  - WAIT_D: lasts READ_LAT cycles. On the last cycle, mem_rdata is captured into data_rdata. Goes to COMMIT.
  - COMMIT: commit=1 for exactly one cycle; retired+=1 (wraps modulo 2^CNT_W). Issues the next fetch: mem_en=1, mem_we=0, mem_addr=pc_next>>ADDR_SHIFT. Goes to WAIT_I.
- Cycles per instruction (commit to commit):
  - no data access: READ_LAT+2.
  - store: READ_LAT+2.
  - load: 2*READ_LAT+2.
- Misalignment: misalign=1 combinationally in EXEC when data_req=1 and data_addr[ADDR_SHIFT-1:0]!=0. The access still uses the truncated address. Forced to 0 when ADDR_SHIFT=0.
- mem_en=0 and mem_we=0 in all states and conditions not listed above.
- Inputs are sampled only in the states named: pc_next in COMMIT; data_* in EXEC; hold in EXEC.
- data_rdata holds its value until the next load capture. instr holds until the next WAIT_I capture.
- Reset mid-access: any in-flight read result is discarded; restart from BOOT.

Decomposition:
- Shared package p_liu_pkg:
  - state enum (BOOT, FETCH, WAIT_I, EXEC, WAIT_D, COMMIT).
  - default DATA_W/ADDR_W constants.
  - RESET_PC constant.
- One natural sub-module: p_liu_lat_counter, a parametrised down-counter that loads READ_LAT-1 and flags done. Used by both WAIT_I and WAIT_D.

Test Plan (defaults, READ_LAT=1, RESET_PC=0, RAM preloaded):
1. Hold rst low 3 cycles, then release -> cycle 1 BOOT with mem_en=0; cycle 2 mem_en=1, mem_addr=0; cycle 4 instr=mem[0], instr_valid=1, retired=0.
2. EXEC with data_req=0, pc_next=0x0002 -> next cycle commit=1, mem_addr=0x0001, retired=1. Next commit 3 cycles later.
3. Load with data_addr=0x0010, mem[8]=0xBEEF -> EXEC mem_addr=0x0008, mem_we=0. COMMIT cycle data_rdata=0xBEEF. Commit spacing 4 cycles.
4. Store with data_addr=0x0021, data_wdata=0x1234 -> in EXEC misalign=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234. Next cycle commit=1.
5. hold=1 for 3 cycles in EXEC -> no mem_en, commit=0, retired unchanged. Commit occurs 1 cycle after hold drops.
6. Assert rst in WAIT_D -> all outputs 0 immediately, retired=0. After release, first fetch is again at address 0; with READ_LAT=3 the bench checks 5-cycle commit spacing.

Source files
------------

// File: rtl/p_liu_pkg.sv
`default_nettype none
// ============================================================================
// p_liu_pkg : shared sequencer state encoding and default widths
// Revision  : 1.0
// ============================================================================
package p_liu_pkg;

  localparam int          DEFAULT_DATA_W   = 16;
  localparam int          DEFAULT_ADDR_W   = 16;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    WAIT_I = 3'd2,
    EXEC   = 3'd3,
    WAIT_D = 3'd4,
    COMMIT = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/p_liu_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// p_liu_mem_sequencer_if : single-port synchronous RAM bus
// Revision               : 1.0
// ============================================================================
interface p_liu_mem_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 15
);
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata,
                  input  mem_rdata);
  modport slave  (input  mem_en, input  mem_we, input  mem_addr, input  mem_wdata,
                  output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/p_liu_lat_counter.sv
`default_nettype none
// ============================================================================
// p_liu_lat_counter : read-latency down-counter, loads LAT-1, flags zero
// Revision          : 1.0
// ============================================================================
module p_liu_lat_counter #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int           W     = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [W-1:0] START = W'(LAT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= START;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/p_liu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// p_liu_mem_sequencer : single-clock fetch/data time-multiplexed RAM sequencer
// Revision            : 1.0
// ============================================================================
module p_liu_mem_sequencer
  import p_liu_pkg::*;
#(
  parameter int          DATA_W     = DEFAULT_DATA_W,
  parameter int          ADDR_W     = DEFAULT_ADDR_W,
  parameter int          ADDR_SHIFT = 1,
  parameter int          READ_LAT   = 1,
  parameter int unsigned RESET_PC   = DEFAULT_RESET_PC,
  parameter int          CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [ADDR_W-1:0]    pc_next,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [DATA_W-1:0]    data_wdata,
  output logic [DATA_W-1:0]    instr,
  output logic                 instr_valid,
  output logic [DATA_W-1:0]    data_rdata,
  output logic                 commit,
  output logic [CNT_W-1:0]     retired,
  output logic                 misalign,
  p_liu_mem_sequencer_if.master mem
);

  localparam int                MEM_AW     = ADDR_W - ADDR_SHIFT;
  localparam logic [ADDR_W-1:0] RESET_BYTE = ADDR_W'(RESET_PC);
  localparam logic [MEM_AW-1:0] RESET_WORD = RESET_BYTE[ADDR_W-1:ADDR_SHIFT];

  state_t            state;
  logic              lat_load;
  logic              lat_dec;
  logic              lat_done;
  logic              exec_go;
  logic              exec_load;
  logic [MEM_AW-1:0] pc_word;
  logic [MEM_AW-1:0] data_word;

  assign pc_word   = pc_next[ADDR_W-1:ADDR_SHIFT];
  assign data_word = data_addr[ADDR_W-1:ADDR_SHIFT];
  assign exec_go   = (state == EXEC) && !hold;
  assign exec_load = exec_go && data_req && !data_we;

  // Every read issue (fetch, next-fetch, load) rearms the shared latency timer.
  assign lat_load = (state == FETCH) || (state == COMMIT) || exec_load;
  assign lat_dec  = (state == WAIT_I) || (state == WAIT_D);

  p_liu_lat_counter #(
    .LAT (READ_LAT)
  ) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (lat_load),
    .dec  (lat_dec),
    .done (lat_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      instr      <= '0;
      data_rdata <= '0;
      retired    <= '0;
    end else begin
      case (state)
        BOOT:   state <= FETCH;
        FETCH:  state <= WAIT_I;
        WAIT_I: begin
          if (lat_done) begin
            instr <= mem.mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (exec_load) begin
            state <= WAIT_D;
          end else if (exec_go) begin
            // Count on entry so the COMMIT cycle already shows the new total.
            state   <= COMMIT;
            retired <= retired + CNT_W'(1);
          end
        end
        WAIT_D: begin
          if (lat_done) begin
            data_rdata <= mem.mem_rdata;
            state      <= COMMIT;
            retired    <= retired + CNT_W'(1);
          end
        end
        COMMIT:  state <= WAIT_I;
        default: state <= BOOT;
      endcase
    end
  end

  assign commit      = (state == COMMIT);
  assign instr_valid = (state == EXEC) || (state == WAIT_D) || (state == COMMIT);

  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      FETCH: begin
        mem.mem_en   = 1'b1;
        mem.mem_addr = RESET_WORD;
      end
      EXEC: begin
        if (exec_go && data_req) begin
          mem.mem_en   = 1'b1;
          mem.mem_we   = data_we;
          mem.mem_addr = data_word;
          if (data_we) begin
            mem.mem_wdata = data_wdata;
          end
        end
      end
      COMMIT: begin
        mem.mem_en   = 1'b1;
        mem.mem_addr = pc_word;
      end
      default: ;
    endcase
  end

  generate
    if (ADDR_SHIFT > 0) begin : g_misalign
      logic unused_pc_lsb;
      assign unused_pc_lsb = ^pc_next[ADDR_SHIFT-1:0];
      assign misalign = (state == EXEC) && data_req && (data_addr[ADDR_SHIFT-1:0] != '0);
    end else begin : g_aligned
      assign misalign = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
